// File: rtl/keypad_unit.sv
// -----------------------------------------------------------------------------
// keypad_unit
//
// Scans and debounces the 4x4 board keypad. The rows are driven low one at a
// time and the synchronized column lines are sampled at the end of each row
// slot. Four slots make one frame. Each frame is classified as NONE, SINGLE or
// MULTI. A small FSM accepts a key after DEBOUNCE_FRAMES matching SINGLE
// frames. It then waits for DEBOUNCE_FRAMES empty frames before it will accept
// another key.
//
// All sequential logic updates on the falling edge of clk.
//
// Ports:
//   clk         system clock (falling edge active)
//   rst_n       asynchronous active-low reset
//   keypad_col  column lines, active-low, bit 3 = leftmost column
//   keypad_row  row drive, active-low one-hot, bit 3 = top row (1 2 3 A)
//   key_coord   {col, row} of an accepted key for one cycle, 8'h00 otherwise
//   key_held    high from key acceptance until its release is accepted
// -----------------------------------------------------------------------------
module keypad_unit #(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_FRAMES = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] keypad_col,
   output logic [3:0] keypad_row,
   output logic [7:0] key_coord,
   output logic       key_held
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_FRAMES);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   // Row index 0 drives the top row (0111). Index 3 drives the bottom row (1110).
   function automatic logic [3:0] row_pattern(input logic [1:0] idx);
      logic [3:0] top;
      top = 4'b1000;
      return ~(top >> idx);
   endfunction

   // ---------------------------------------------------------------------------
   // Column synchronizer. It resets to the idle (pulled-up) level so that no
   // key is seen before real samples arrive.
   // ---------------------------------------------------------------------------
   logic [3:0] col_meta;
   logic [3:0] col_sync;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta <= 4'hF;
         col_sync <= 4'hF;
      end else begin
         col_meta <= keypad_col;
         col_sync <= col_meta;
      end
   end

   // ---------------------------------------------------------------------------
   // Slot counter and row sequencer
   // ---------------------------------------------------------------------------
   logic [SW-1:0] slot_cnt;
   logic [1:0]    row_idx;
   logic          slot_end;
   logic          frame_end;

   assign slot_end  = (slot_cnt == SLOT_LAST);
   assign frame_end = slot_end && (row_idx == 2'd3);

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt <= '0;
         row_idx  <= 2'd0;
      end else if (slot_end) begin
         slot_cnt <= '0;
         row_idx  <= row_idx + 2'd1;   // 3 wraps to 0 (top row)
      end else begin
         slot_cnt <= slot_cnt + SW'(1);
      end
   end

   assign keypad_row = row_pattern(row_idx);

   // ---------------------------------------------------------------------------
   // Frame capture. Only the first three rows are stored. The bottom row's
   // sample is taken in the frame-end cycle itself, so it is used straight from
   // the synchronizer.
   // ---------------------------------------------------------------------------
   logic [3:0] cap_0;
   logic [3:0] cap_1;
   logic [3:0] cap_2;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_0 <= 4'hF;
         cap_1 <= 4'hF;
         cap_2 <= 4'hF;
      end else if (slot_end) begin
         case (row_idx)
            2'd0:    cap_0 <= col_sync;
            2'd1:    cap_1 <= col_sync;
            2'd2:    cap_2 <= col_sync;
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Frame classification (meaningful only when frame_end is high)
   // ---------------------------------------------------------------------------
   logic [3:0] frame_col [0:3];
   logic [2:0] active_rows;
   logic [3:0] sel_col;
   logic [3:0] sel_row;
   logic       frame_none;
   logic       frame_single;
   logic [7:0] frame_coord;

   always_comb begin
      frame_col[0] = cap_0;
      frame_col[1] = cap_1;
      frame_col[2] = cap_2;
      frame_col[3] = col_sync;
      active_rows  = 3'd0;
      sel_col      = 4'hF;
      sel_row      = 4'hF;
      for (int i = 0; i < 4; i++) begin
         if (frame_col[i] != 4'hF) begin
            active_rows = active_rows + 3'd1;
            sel_col     = frame_col[i];
            sel_row     = row_pattern(2'(i));
         end
      end
      frame_none   = (active_rows == 3'd0);
      // SINGLE needs exactly one active row with exactly one column low.
      // Two lows in one row, or lows in two rows, make the frame MULTI.
      frame_single = (active_rows == 3'd1) && ($countones(~sel_col) == 1);
      frame_coord  = {sel_col, sel_row};
   end

   // ---------------------------------------------------------------------------
   // Debounce FSM. It steps only at frame end.
   // ---------------------------------------------------------------------------
   state_t        state;
   state_t        state_n;
   logic [7:0]    cand;
   logic [7:0]    cand_n;
   logic [DW-1:0] cnt;
   logic [DW-1:0] cnt_n;
   logic [DW-1:0] cnt_inc;
   logic [7:0]    coord_n;
   logic          held_n;

   // cnt is always below DEBOUNCE_FRAMES when it is incremented, so it never
   // wraps.
   assign cnt_inc = cnt + DW'(1);

   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      coord_n = 8'h00;
      held_n  = key_held;

      if (frame_end) begin
         case (state)
            ST_IDLE: begin
               if (frame_single) begin
                  cand_n = frame_coord;
                  if (DEBOUNCE_FRAMES == 1) begin
                     coord_n = frame_coord;
                     held_n  = 1'b1;
                     cnt_n   = '0;
                     state_n = ST_HELD;
                  end else begin
                     cnt_n   = DW'(1);
                     state_n = ST_DEBOUNCE;
                  end
               end
            end

            ST_DEBOUNCE: begin
               if (frame_single && (frame_coord == cand)) begin
                  if (cnt_inc == DB_LAST) begin
                     coord_n = cand;
                     held_n  = 1'b1;
                     cnt_n   = '0;
                     state_n = ST_HELD;
                  end else begin
                     cnt_n = cnt_inc;
                  end
               end else begin
                  // A different key, a release or a chord abandons the
                  // candidate. A new key is picked up on a later frame.
                  cnt_n   = '0;
                  state_n = ST_IDLE;
               end
            end

            ST_HELD: begin
               if (frame_none) begin
                  if (cnt_inc == DB_LAST) begin
                     held_n  = 1'b0;
                     cnt_n   = '0;
                     state_n = ST_IDLE;
                  end else begin
                     cnt_n = cnt_inc;
                  end
               end else begin
                  // Any key activity, including a rollover key, restarts the
                  // release count.
                  cnt_n = '0;
               end
            end

            default: begin
               cnt_n   = '0;
               held_n  = 1'b0;
               state_n = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cand      <= 8'h00;
         cnt       <= '0;
         key_coord <= 8'h00;
         key_held  <= 1'b0;
      end else begin
         state     <= state_n;
         cand      <= cand_n;
         cnt       <= cnt_n;
         key_coord <= coord_n;   // coord_n is 8'h00 outside the accept cycle
         key_held  <= held_n;
      end
   end

endmodule

// File: tb/tb_keypad_unit.sv
// -----------------------------------------------------------------------------
// tb_keypad_unit
//
// Directed bench for keypad_unit with SCAN_DIV=4 and DEBOUNCE_FRAMES=2, so one
// frame is 16 clocks. A keypad model drives the column lines from the row drive
// and a pressed-key matrix. All DUT state changes on the falling edge, so the
// bench changes inputs and samples outputs 1-2 time units after a falling edge,
// or on a rising edge.
// -----------------------------------------------------------------------------
module tb_keypad_unit;

   localparam int SCAN_DIV        = 4;
   localparam int DEBOUNCE_FRAMES = 2;
   localparam int FRAME           = 4 * SCAN_DIV;

   logic       clk;
   logic       rst_n;
   logic [3:0] keypad_col;
   logic [3:0] keypad_row;
   logic [7:0] key_coord;
   logic       key_held;

   keypad_unit #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .keypad_col (keypad_col),
      .keypad_row (keypad_row),
      .key_coord  (key_coord),
      .key_held   (key_held)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- keypad model ----------------
   // press_mat[r][c] = 1 means the key at row bit r, column bit c is pressed.
   logic [3:0] press_mat [4];

   always_comb begin
      keypad_col = 4'hF;
      for (int r = 0; r < 4; r++)
         if (!keypad_row[r]) keypad_col = keypad_col & ~press_mat[r];
   end

   task automatic clear_keys();
      for (int r = 0; r < 4; r++) press_mat[r] = 4'h0;
   endtask

   // ---------------- scoreboard ----------------
   int checks = 0;
   int passes = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Every pulse seen must match the next expected key. Pulses with nothing
   // expected are failures.
   always @(posedge clk) begin
      if (rst_n && key_coord != 8'h00) begin
         if (exp_q.size() == 0) check("unexpected_pulse", {24'h0, key_coord}, 32'h0);
         else check("pulse_value", {24'h0, key_coord}, {24'h0, exp_q.pop_front()});
      end
   end

   // Returns 2 time units after the n-th following frame-end edge.
   task automatic wait_frames(input int n);
      repeat (FRAME * n) @(negedge clk);
      #2;
   endtask

   task automatic check_out(input string name, input logic [7:0] coord, input logic held);
      check({name, "_coord"}, {24'h0, key_coord}, {24'h0, coord});
      check({name, "_held"},  {31'h0, key_held},  {31'h0, held});
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string      name;
      int         row;        // row bit (3 = top)
      logic [3:0] col_mask;   // column bit(s) pulled low
      int         hold;       // frames held
      logic [7:0] exp_coord;  // hand-computed {col, row}
   } vec_t;

   vec_t vecs [3];

   initial begin
      logic [3:0] top;
      logic [3:0] exp_row;

      vecs[0] = '{name: "key_1", row: 3, col_mask: 4'b1000, hold: 8, exp_coord: 8'h77};
      vecs[1] = '{name: "key_A", row: 3, col_mask: 4'b0001, hold: 3, exp_coord: 8'hE7};
      vecs[2] = '{name: "key_hash", row: 0, col_mask: 4'b0010, hold: 3, exp_coord: 8'hDE};

      clear_keys();
      rst_n = 1'b0;
      #3;
      check("reset_row", {28'h0, keypad_row}, 32'h7);
      check_out("reset", 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      // Idle scan: rows step every SCAN_DIV clocks. No key activity for 10 frames.
      top = 4'b1000;
      for (int i = 0; i < 10 * FRAME; i++) begin
         @(posedge clk);
         exp_row = ~(top >> ((i / SCAN_DIV) % 4));
         check("idle_row", {28'h0, keypad_row}, {28'h0, exp_row});
         check("idle_quiet", {23'h0, key_held, key_coord}, 32'h0);
      end
      @(negedge clk);
      #2;   // frame start

      // Single keys: table-driven.
      for (int v = 0; v < 3; v++) begin
         press_mat[vecs[v].row] = vecs[v].col_mask;
         exp_q.push_back(vecs[v].exp_coord);
         wait_frames(1);
         check_out({vecs[v].name, "_f1"}, 8'h00, 1'b0);
         wait_frames(1);
         check_out({vecs[v].name, "_accept"}, vecs[v].exp_coord, 1'b1);
         wait_frames(vecs[v].hold - 2);
         check_out({vecs[v].name, "_holding"}, 8'h00, 1'b1);
         clear_keys();
         wait_frames(1);
         check_out({vecs[v].name, "_rel1"}, 8'h00, 1'b1);
         wait_frames(1);
         check_out({vecs[v].name, "_rel2"}, 8'h00, 1'b0);
      end

      // Bounce on '5': present, absent, present, gone. No pulse.
      press_mat[2] = 4'b0100;
      wait_frames(1);
      clear_keys();
      wait_frames(1);
      press_mat[2] = 4'b0100;
      wait_frames(1);
      clear_keys();
      wait_frames(2);
      check_out("bounce", 8'h00, 1'b0);

      // '5' held for 3 frames gives one pulse.
      press_mat[2] = 4'b0100;
      exp_q.push_back(8'hBB);
      wait_frames(1);
      check_out("key_5_f1", 8'h00, 1'b0);
      wait_frames(1);
      check_out("key_5_accept", 8'hBB, 1'b1);
      wait_frames(1);
      clear_keys();
      wait_frames(2);
      check_out("key_5_rel", 8'h00, 1'b0);

      // '1' and '2' together (same row) form a chord: nothing is accepted.
      press_mat[3] = 4'b1100;
      wait_frames(5);
      check_out("chord", 8'h00, 1'b0);
      press_mat[3] = 4'b1000;
      exp_q.push_back(8'h77);
      wait_frames(1);
      check_out("chord_rel2_f1", 8'h00, 1'b0);
      wait_frames(1);
      check_out("chord_rel2_accept", 8'h77, 1'b1);
      clear_keys();
      wait_frames(2);
      check_out("chord_release", 8'h00, 1'b0);

      // Reset during DEBOUNCE on '9'.
      press_mat[1] = 4'b0010;
      wait_frames(1);
      check_out("k9_deb", 8'h00, 1'b0);
      rst_n = 1'b0;
      #1;
      check("k9_rst1_row", {28'h0, keypad_row}, 32'h7);
      check_out("k9_rst1", 8'h00, 1'b0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      exp_q.push_back(8'hDD);
      wait_frames(1);
      check_out("k9_after_rst1_f1", 8'h00, 1'b0);
      wait_frames(1);
      check_out("k9_after_rst1_accept", 8'hDD, 1'b1);

      // Reset while '9' is held, in the middle of a row slot away from the top row.
      wait_frames(1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("k9_rst2_row", {28'h0, keypad_row}, 32'h7);
      check_out("k9_rst2", 8'h00, 1'b0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      exp_q.push_back(8'hDD);
      wait_frames(1);
      check_out("k9_after_rst2_f1", 8'h00, 1'b0);
      wait_frames(1);
      check_out("k9_after_rst2_accept", 8'hDD, 1'b1);
      clear_keys();
      wait_frames(2);
      check_out("k9_release", 8'h00, 1'b0);

      check("exp_q_drained", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/keypad_unit.md
Name: keypad_unit

Overview:
Matrix-keypad scanner and debouncer for the 4x4 board keypad. It sits directly upstream of the keypad input stage.
- Drives the row lines one at a time and samples the column lines.
- Debounces presses and releases over whole scan frames.
- Emits each accepted key exactly once, as a one-cycle key_coord pulse in the {col_val, row_val} active-low format consumed downstream.

Parameters:
SCAN_DIV, 50000, clk cycles per row slot (minimum 4; 0.5 ms at 100 MHz).
DEBOUNCE_FRAMES, 5, number of consecutive identical full-scan frames needed to accept a press or a release (minimum 1).

Ports:
clk  input  1  system clock; all sequential logic in this block updates on the falling edge.
rst_n  input  1  asynchronous, active-low reset.
keypad_col  input  4  column lines, active-low, externally pulled up; bit 3 = leftmost column.
keypad_row  output  4  row drive, active-low one-hot; bit 3 = top row (keys 1 2 3 A).
key_coord  output  8  {col_val, row_val} of the accepted key, both active-low one-hot; 8'h00 when no event.
key_held  output  1  high from acceptance of a key until its release is accepted (LED/diagnostics).

Behaviour:
- Reset (async, rst_n low):
  - keypad_row = 4'b0111, key_coord = 8'h00, key_held = 0.
  - Slot counter, row index, frame capture, debounce counter and FSM all clear; FSM = IDLE.
  - A press in progress is discarded and no pulse is emitted.
  - After release of reset, scanning restarts at row 3.
- Column input: keypad_col passes through a 2-FF synchronizer before any use.
- Scan timing:
  - The slot counter runs 0..SCAN_DIV-1.
  - Row order: 0111 -> 1011 -> 1101 -> 1110, then wraps.
  - The synchronized column value is captured in the last cycle of each slot (count = SCAN_DIV-1), then the row advances.
  - Frame = 4*SCAN_DIV cycles; frame end = the capture cycle of row 1110.
- Frame classification at frame end:
  - NONE: all four captures are 4'hF.
  - SINGLE: exactly one row has exactly one column low. frame_coord = {captured col, row pattern}.
  - MULTI: anything else, including one row with two columns low.
- FSM, evaluated only at frame end:
  - IDLE: SINGLE -> DEBOUNCE, cand = frame_coord, cnt = 1; if DEBOUNCE_FRAMES = 1, accept immediately. NONE or MULTI -> stay.
  - DEBOUNCE: SINGLE equal to cand -> cnt+1; when cnt reaches DEBOUNCE_FRAMES, accept. SINGLE differing from cand, NONE, or MULTI -> IDLE with no pulse (a different key restarts detection only on the next frame).
  - Accept: key_coord = cand for exactly one falling-edge-to-falling-edge period (spanning exactly one rising edge); key_held = 1; -> HELD with cnt = 0.
  - HELD: SINGLE or MULTI -> cnt = 0, stay. NONE -> cnt+1; when cnt reaches DEBOUNCE_FRAMES -> IDLE, key_held = 0.
- Repeat and rollover:
  - No auto-repeat: holding a key yields one pulse only.
  - Pressing a second key while one is held yields nothing; a new key is accepted only after a full release.
- Latency: the pulse appears on the falling edge following the frame-end capture of the DEBOUNCE_FRAMES-th consecutive matching frame.
- key_coord is 8'h00 in every cycle other than the accept pulse.
- Counter widths: $clog2(SCAN_DIV) for the slot counter; $clog2(DEBOUNCE_FRAMES+1) for the debounce counter. Neither counter ever wraps past its terminal value.

Test Plan:
- SCAN_DIV=4, DEBOUNCE_FRAMES=2 (frame = 16 cycles). Reset, then idle: keypad_row cycles 0111, 1011, 1101, 1110 every 4 cycles; key_coord stays 8'h00 and key_held stays 0 for 10 frames.
- Hold key '1' for 8 frames (model pulls col[3] low while row[3] is low): exactly one pulse key_coord = 8'h77 at the end of frame 2 of the press; key_held = 1; no further pulses. Release: key_held falls after 2 empty frames.
- Hold key 'A' (col 1110, row 0111), then '#' (col 1101, row 1110) after release: pulses 8'hE7, then 8'hDE, one each.
- Bounce: '5' present 1 frame, absent 1 frame, present 1 frame, then gone -> no pulse. Then '5' held 3 frames -> single pulse 8'hBB.
- Two keys '1' and '2' held together for 5 frames -> no pulse. Release '2' and keep '1' -> pulse 8'h77 after 2 frames.
- Assert rst_n low while '9' is in DEBOUNCE (after 1 frame) and while held: no pulse; outputs return to reset values immediately. Keep '9' held through deassertion -> one fresh pulse 8'hDD after 2 frames.
